// File: rtl/sad_array_builder.sv
// Producer for the 16-candidate SAD array: accumulates |cur-ref| per candidate from a
// serial pixel-pair stream and presents the packed sums with a valid/ready handshake.
module sad_array_builder #(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int PIXEL_BIT_DEPTH   = 8,
    parameter int PIXELS_PER_BLOCK  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [PIXEL_BIT_DEPTH-1:0]      cur_pixel,
    input  logic [PIXEL_BIT_DEPTH-1:0]      ref_pixel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [ELEMENT_BIT_DEPTH*16-1:0] sad_array,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int NUM_CAND  = 16;
    localparam int PIX_CNT_W = $clog2(PIXELS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                       state_r;
    logic [PIX_CNT_W-1:0]         pix_cnt_r;
    logic [3:0]                   cand_cnt_r;
    logic [ELEMENT_BIT_DEPTH-1:0] acc_r [NUM_CAND];
    logic                         in_ready_r;
    logic                         out_valid_r;
    logic                         busy_r;

    logic                         beat_s;
    logic                         last_pix_s;
    logic                         last_beat_s;
    logic [PIXEL_BIT_DEPTH-1:0]   abs_diff_s;
    logic [ELEMENT_BIT_DEPTH-1:0] acc_next_s;

    function automatic logic [PIXEL_BIT_DEPTH-1:0] abs_diff(
        input logic [PIXEL_BIT_DEPTH-1:0] a,
        input logic [PIXEL_BIT_DEPTH-1:0] b
    );
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    function automatic logic [ELEMENT_BIT_DEPTH-1:0] sat_add(
        input logic [ELEMENT_BIT_DEPTH-1:0] acc,
        input logic [PIXEL_BIT_DEPTH-1:0]   d
    );
        logic [ELEMENT_BIT_DEPTH:0] sum;
        sum = {1'b0, acc} + (ELEMENT_BIT_DEPTH+1)'(d);
        if (sum[ELEMENT_BIT_DEPTH]) begin
            return {ELEMENT_BIT_DEPTH{1'b1}};
        end else begin
            return sum[ELEMENT_BIT_DEPTH-1:0];
        end
    endfunction

    // Beat qualification and the next value of the active accumulator.
    always_comb begin
        beat_s      = in_valid & in_ready_r;
        last_pix_s  = (pix_cnt_r == PIX_CNT_W'(PIXELS_PER_BLOCK - 1));
        last_beat_s = beat_s & last_pix_s & (cand_cnt_r == 4'd15);
        abs_diff_s  = abs_diff(cur_pixel, ref_pixel);
        acc_next_s  = sat_add(acc_r[cand_cnt_r], abs_diff_s);
    end

    // Control FSM, counters, accumulators and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pix_cnt_r   <= {PIX_CNT_W{1'b0}};
            cand_cnt_r  <= 4'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                acc_r[i] <= {ELEMENT_BIT_DEPTH{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= ACCUM;
                        pix_cnt_r  <= {PIX_CNT_W{1'b0}};
                        cand_cnt_r <= 4'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        for (int i = 0; i < NUM_CAND; i++) begin
                            acc_r[i] <= {ELEMENT_BIT_DEPTH{1'b0}};
                        end
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        acc_r[cand_cnt_r] <= acc_next_s;
                        if (last_pix_s) begin
                            pix_cnt_r  <= {PIX_CNT_W{1'b0}};
                            cand_cnt_r <= cand_cnt_r + 4'd1;
                        end else begin
                            pix_cnt_r <= pix_cnt_r + PIX_CNT_W'(1);
                        end
                        if (last_beat_s) begin
                            state_r     <= PRESENT;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CAND; k++) begin : g_pack
        assign sad_array[k*ELEMENT_BIT_DEPTH +: ELEMENT_BIT_DEPTH] = acc_r[k];
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_sad_array_builder.sv
// Directed self-checking bench for sad_array_builder (default parameters).
module tb_sad_array_builder;

    localparam int E = 14;
    localparam int P = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [P-1:0]  cur_pixel;
    logic [P-1:0]  ref_pixel;
    logic          in_valid;
    logic          in_ready;
    logic [E*16-1:0] sad_array;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    sad_array_builder #(.ELEMENT_BIT_DEPTH(E), .PIXEL_BIT_DEPTH(P), .PIXELS_PER_BLOCK(64)) dut (
        .clk(clk), .rst(rst), .start(start), .cur_pixel(cur_pixel), .ref_pixel(ref_pixel),
        .in_valid(in_valid), .in_ready(in_ready), .sad_array(sad_array),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [E*16-1:0] exp_sad(input int mode);
        logic [E*16-1:0] r;
        int e;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            case (mode)
                0:       e = 0;
                1:       e = 64 * k;
                2:       e = (k == 9) ? 0 : 1024;
                default: e = 64 * 255;
            endcase
            r[k*E +: E] = E'(e);
        end
        return r;
    endfunction

    // Reference MIN_16 behaviour: lowest value, first index on ties.
    function automatic logic [3:0] min_index(input logic [E*16-1:0] s);
        logic [3:0]   idx;
        logic [E-1:0] best;
        idx  = 4'd0;
        best = s[E-1:0];
        for (int k = 1; k < 16; k++) begin
            if (s[k*E +: E] < best) begin
                best = s[k*E +: E];
                idx  = 4'(k);
            end
        end
        return idx;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds up to max_beats accepted beats; returns at a negedge with in_valid low.
    task automatic feed(input int mode, input bit gaps, input int max_beats,
                        input bit pulse_start, output int beats);
        int  cyc;
        int  cand;
        bit  saw_early;
        cyc       = 0;
        beats     = 0;
        saw_early = 1'b0;
        while (beats < max_beats && cyc < 5000) begin
            cand      = beats / 64;
            in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (pulse_start && beats == 100) ? 1'b1 : 1'b0;
            case (mode)
                0:       begin cur_pixel = 8'h80; ref_pixel = 8'h80; end
                1:       begin cur_pixel = 8'h10; ref_pixel = 8'h10 + 8'(cand); end
                2:       begin cur_pixel = 8'h10; ref_pixel = (cand == 9) ? 8'h10 : 8'h20; end
                default: begin cur_pixel = 8'hFF; ref_pixel = 8'h00; end
            endcase
            if (beats == max_beats - 1 && !saw_early) begin
                check("out_valid_before_last", {255'd0, out_valid}, 256'd0);
                saw_early = 1'b1;
            end
            if (in_valid && in_ready) beats++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, {255'd0, out_valid}, 256'd0);
        check({tag, "_busy_drop"}, {255'd0, busy}, 256'd0);
    endtask

    initial begin
        int beats;
        logic [E*16-1:0] held;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cur_pixel = 8'h00; ref_pixel = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_sad", 256'(sad_array), 256'd0);
        rst = 1'b0;
        @(negedge clk);

        // Equal pixels give all-zero SADs
        do_start();
        check("t1_in_ready", {255'd0, in_ready}, 256'd1);
        check("t1_busy", {255'd0, busy}, 256'd1);
        feed(0, 1'b0, 1024, 1'b0, beats);
        check("t1_out_valid", {255'd0, out_valid}, 256'd1);
        check("t1_in_ready_present", {255'd0, in_ready}, 256'd0);
        check("t1_sad", 256'(sad_array), 256'(exp_sad(0)));
        release_out("t1");

        // Candidate k differs by k per pixel
        do_start();
        feed(1, 1'b0, 1024, 1'b0, beats);
        check("t2_out_valid", {255'd0, out_valid}, 256'd1);
        check("t2_sad", 256'(sad_array), 256'(exp_sad(1)));
        check("t2_k15", 256'(sad_array[15*E +: E]), 256'h3C0);
        check("t2_min_idx", 256'(min_index(sad_array)), 256'd0);
        release_out("t2");

        // Data in IDLE is neither accepted nor accumulated
        in_valid = 1'b1; cur_pixel = 8'hFF; ref_pixel = 8'h00;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("idle_in_ready", {255'd0, in_ready}, 256'd0);
        check("idle_sad", 256'(sad_array), 256'(exp_sad(1)));

        // Candidate 9 is the unique minimum; back-pressure and start during PRESENT
        do_start();
        feed(2, 1'b0, 1024, 1'b0, beats);
        check("t3_min_idx", 256'(min_index(sad_array)), 256'd9);
        held = sad_array;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            check("t3_hold_ov", {255'd0, out_valid}, 256'd1);
            check("t3_hold_sad", 256'(sad_array), 256'(exp_sad(2)));
        end
        start = 1'b1;
        release_out("t3");
        start = 1'b0;
        @(negedge clk);
        check("t3_start_at_hs_ignored", {255'd0, busy}, 256'd0);
        check("t3_sad_after", 256'(sad_array), 256'(held));

        // Random gaps with a start pulse mid-ACCUM
        do_start();
        feed(3, 1'b1, 1024, 1'b1, beats);
        check("t4_beats", 256'(beats), 256'd1024);
        check("t4_out_valid", {255'd0, out_valid}, 256'd1);
        check("t4_sad", 256'(sad_array), 256'(exp_sad(3)));
        release_out("t4");

        // Async reset mid-ACCUM, then a clean search
        do_start();
        feed(1, 1'b0, 300, 1'b0, beats);
        check("t5_busy_mid", {255'd0, busy}, 256'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_in_ready", {255'd0, in_ready}, 256'd0);
        check("t5_rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("t5_rst_busy", {255'd0, busy}, 256'd0);
        check("t5_rst_sad", 256'(sad_array), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start();
        feed(1, 1'b0, 1024, 1'b0, beats);
        check("t5_out_valid", {255'd0, out_valid}, 256'd1);
        check("t5_sad", 256'(sad_array), 256'(exp_sad(1)));
        release_out("t5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
